// File: rtl/id_ex_pkg.sv
// Shared widths, ALU command encodings and field structs for the ID/EX pipeline register.
// Optional FWD_SRC_EN adds the forwarding source addresses to data_t.
package id_ex_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int CMD_W      = 4;
  localparam int SHOP_W     = 12;
  localparam int SIMM_W     = 24;
  localparam int SR_W       = 4;

  localparam logic [CMD_W-1:0] EXE_NOP = 4'b0000;
  localparam logic [CMD_W-1:0] EXE_MOV = 4'b0001;
  localparam logic [CMD_W-1:0] EXE_ADD = 4'b0010;
  localparam logic [CMD_W-1:0] EXE_ADC = 4'b0011;
  localparam logic [CMD_W-1:0] EXE_SUB = 4'b0100;
  localparam logic [CMD_W-1:0] EXE_SBC = 4'b0101;
  localparam logic [CMD_W-1:0] EXE_AND = 4'b0110;
  localparam logic [CMD_W-1:0] EXE_ORR = 4'b0111;
  localparam logic [CMD_W-1:0] EXE_EOR = 4'b1000;
  localparam logic [CMD_W-1:0] EXE_MVN = 4'b1001;

  typedef struct packed {
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             b;
    logic             s;
    logic [CMD_W-1:0] exe_cmd;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     val_rn;
    logic [DATA_W-1:0]     val_rm;
    logic                  i;
    logic [SHOP_W-1:0]     shift_operand;
    logic [SIMM_W-1:0]     simm24;
    logic [REG_ADDR_W-1:0] dest;
    logic [SR_W-1:0]       sr;
`ifdef FWD_SRC_EN
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
`endif
  } data_t;

endpackage

// File: rtl/stage_field_reg.sv
// Generic pipeline field register: reset/clear to zero beats hold, otherwise load d.
module stage_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= '0;
    end else if (!hold) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID->EX pipeline register with freeze (hold), flush (bubble) and a valid bit.
// Define FWD_SRC_EN to also carry the source register addresses to the forwarding unit.
module id_ex_reg #(
  parameter int DATA_W     = id_ex_pkg::DATA_W,
  parameter int REG_ADDR_W = id_ex_pkg::REG_ADDR_W,
  parameter int CMD_W      = id_ex_pkg::CMD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  input  logic                  id_mem_w_en,
  input  logic                  id_b,
  input  logic                  id_s,
  input  logic [CMD_W-1:0]      id_exe_cmd,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_val_rn,
  input  logic [DATA_W-1:0]     id_val_rm,
  input  logic                  id_i,
  input  logic [11:0]           id_shift_operand,
  input  logic [23:0]           id_simm24,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic [3:0]            id_sr,
`ifdef FWD_SRC_EN
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  output logic [REG_ADDR_W-1:0] ex_src1,
  output logic [REG_ADDR_W-1:0] ex_src2,
`endif
  output logic                  ex_wb_en,
  output logic                  ex_mem_r_en,
  output logic                  ex_mem_w_en,
  output logic                  ex_b,
  output logic                  ex_s,
  output logic [CMD_W-1:0]      ex_exe_cmd,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_val_rn,
  output logic [DATA_W-1:0]     ex_val_rm,
  output logic                  ex_i,
  output logic [11:0]           ex_shift_operand,
  output logic [23:0]           ex_simm24,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [3:0]            ex_sr,
  output logic                  ex_mem_cmd,
  output logic                  ex_valid
);
  import id_ex_pkg::*;

  // Stage protocol: freeze holds every field bit-stable; flush inserts an all-zero
  // bubble and wins over freeze; an invalid ID slot loads with control bits zeroed.
  ctrl_t w_ctrl_d, w_ctrl_q;
  data_t w_data_d, w_data_q;
  logic  r_valid;
  logic  r_mem_cmd;

  always_comb begin
    w_ctrl_d = '0;
    if (id_valid) begin
      w_ctrl_d.wb_en    = id_wb_en;
      w_ctrl_d.mem_r_en = id_mem_r_en;
      w_ctrl_d.mem_w_en = id_mem_w_en;
      w_ctrl_d.b        = id_b;
      w_ctrl_d.s        = id_s;
      w_ctrl_d.exe_cmd  = id_exe_cmd;
    end
  end

  always_comb begin
    w_data_d               = '0;
    w_data_d.pc            = id_pc;
    w_data_d.val_rn        = id_val_rn;
    w_data_d.val_rm        = id_val_rm;
    w_data_d.i             = id_i;
    w_data_d.shift_operand = id_shift_operand;
    w_data_d.simm24        = id_simm24;
    w_data_d.dest          = id_dest;
    w_data_d.sr            = id_sr;
`ifdef FWD_SRC_EN
    w_data_d.src1          = id_src1;
    w_data_d.src2          = id_src2;
`endif
  end

  stage_field_reg #(.W($bits(ctrl_t))) u_ctrl_reg (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .hold (freeze),
    .d    (w_ctrl_d),
    .q    (w_ctrl_q)
  );

  stage_field_reg #(.W($bits(data_t))) u_data_reg (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .hold (freeze),
    .d    (w_data_d),
    .q    (w_data_q)
  );

  // mem_cmd is precomputed here so the operand generator sees a registered signal.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid   <= 1'b0;
      r_mem_cmd <= 1'b0;
    end else if (!freeze) begin
      r_valid   <= id_valid;
      r_mem_cmd <= id_valid & (id_mem_r_en | id_mem_w_en);
    end
  end

  assign ex_wb_en         = w_ctrl_q.wb_en;
  assign ex_mem_r_en      = w_ctrl_q.mem_r_en;
  assign ex_mem_w_en      = w_ctrl_q.mem_w_en;
  assign ex_b             = w_ctrl_q.b;
  assign ex_s             = w_ctrl_q.s;
  assign ex_exe_cmd       = w_ctrl_q.exe_cmd;
  assign ex_pc            = w_data_q.pc;
  assign ex_val_rn        = w_data_q.val_rn;
  assign ex_val_rm        = w_data_q.val_rm;
  assign ex_i             = w_data_q.i;
  assign ex_shift_operand = w_data_q.shift_operand;
  assign ex_simm24        = w_data_q.simm24;
  assign ex_dest          = w_data_q.dest;
  assign ex_sr            = w_data_q.sr;
`ifdef FWD_SRC_EN
  assign ex_src1          = w_data_q.src1;
  assign ex_src2          = w_data_q.src2;
`endif
  assign ex_mem_cmd       = r_mem_cmd;
  assign ex_valid         = r_valid;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed plan steps, then randomized cycles vs a reference model.
module tb_id_ex_reg;

`ifdef FWD_SRC_EN
  localparam int DW = 149;
`else
  localparam int DW = 141;
`endif
  localparam int CW = 11;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, id_valid;
  logic        id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_i;
  logic [3:0]  id_exe_cmd, id_dest, id_sr;
  logic [31:0] id_pc, id_val_rn, id_val_rm;
  logic [11:0] id_shift_operand;
  logic [23:0] id_simm24;
  logic        ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_i, ex_mem_cmd, ex_valid;
  logic [3:0]  ex_exe_cmd, ex_dest, ex_sr;
  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [11:0] ex_shift_operand;
  logic [23:0] ex_simm24;
`ifdef FWD_SRC_EN
  logic [3:0]  id_src1, id_src2, ex_src1, ex_src2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what EX should hold, grouped as control and data vectors.
  logic [CW-1:0] m_ctrl;
  logic [DW-1:0] m_data;
  logic [CW-1:0] obs_ctrl;
  logic [DW-1:0] obs_data;
  logic [CW-1:0] snap_ctrl;
  logic [DW-1:0] snap_data;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
    .id_b(id_b), .id_s(id_s), .id_exe_cmd(id_exe_cmd), .id_pc(id_pc),
    .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_i(id_i),
    .id_shift_operand(id_shift_operand), .id_simm24(id_simm24), .id_dest(id_dest),
    .id_sr(id_sr),
`ifdef FWD_SRC_EN
    .id_src1(id_src1), .id_src2(id_src2), .ex_src1(ex_src1), .ex_src2(ex_src2),
`endif
    .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
    .ex_b(ex_b), .ex_s(ex_s), .ex_exe_cmd(ex_exe_cmd), .ex_pc(ex_pc),
    .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_i(ex_i),
    .ex_shift_operand(ex_shift_operand), .ex_simm24(ex_simm24), .ex_dest(ex_dest),
    .ex_sr(ex_sr), .ex_mem_cmd(ex_mem_cmd), .ex_valid(ex_valid)
  );

  assign obs_ctrl = {ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_exe_cmd,
                     ex_mem_cmd, ex_valid};
`ifdef FWD_SRC_EN
  assign obs_data = {ex_pc, ex_val_rn, ex_val_rm, ex_i, ex_shift_operand, ex_simm24,
                     ex_dest, ex_sr, ex_src1, ex_src2};
`else
  assign obs_data = {ex_pc, ex_val_rn, ex_val_rm, ex_i, ex_shift_operand, ex_simm24,
                     ex_dest, ex_sr};
`endif

  function automatic logic [CW-1:0] want_ctrl();
    logic v;
    v = id_valid;
    return {id_wb_en & v, id_mem_r_en & v, id_mem_w_en & v, id_b & v, id_s & v,
            v ? id_exe_cmd : 4'h0, v & (id_mem_r_en | id_mem_w_en), v};
  endfunction

  function automatic logic [DW-1:0] want_data();
`ifdef FWD_SRC_EN
    return {id_pc, id_val_rn, id_val_rm, id_i, id_shift_operand, id_simm24, id_dest, id_sr,
            id_src1, id_src2};
`else
    return {id_pc, id_val_rn, id_val_rm, id_i, id_shift_operand, id_simm24, id_dest, id_sr};
`endif
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_ctrl"}, 256'(obs_ctrl), 256'(m_ctrl));
    check({tag, "_data"}, 256'(obs_data), 256'(m_data));
  endtask

  task automatic rand_inputs();
    id_valid         = 1'b1;
    id_wb_en         = 1'($urandom);
    id_mem_r_en      = 1'($urandom);
    id_mem_w_en      = 1'($urandom);
    id_b             = 1'($urandom);
    id_s             = 1'($urandom);
    id_i             = 1'($urandom);
    id_exe_cmd       = 4'($urandom);
    id_dest          = 4'($urandom);
    id_sr            = 4'($urandom);
    id_pc            = $urandom;
    id_val_rn        = $urandom;
    id_val_rm        = $urandom;
    id_shift_operand = 12'($urandom);
    id_simm24        = 24'($urandom);
`ifdef FWD_SRC_EN
    id_src1          = 4'($urandom);
    id_src2          = 4'($urandom);
`endif
  endtask

  // One clock edge: the model applies rst > flush > freeze > load, then outputs settle.
  task automatic tick();
    @(posedge clk);
    if (rst || flush) begin
      m_ctrl = '0;
      m_data = '0;
    end else if (!freeze) begin
      m_ctrl = want_ctrl();
      m_data = want_data();
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    rand_inputs();
    m_ctrl = '0; m_data = '0;
    tick();
    tick();
    check_model("reset_initial");
    rst = 1'b0;

    // Load something non-zero, then reset empties it.
    rand_inputs();
    id_wb_en = 1'b1;
    tick();
    check_model("load_nonzero");
    rst = 1'b1;
    tick();
    check("reset_valid", 256'(ex_valid), 256'(0));
    check("reset_all", 256'({obs_ctrl, obs_data}), 256'(0));
    rst = 1'b0;

    // Immediate operand load.
    rand_inputs();
    id_i = 1'b1; id_shift_operand = 12'h2FF; id_val_rm = 32'h1234_5678;
    id_mem_r_en = 1'b1; id_mem_w_en = 1'b0;
    tick();
    check("load_shop", 256'(ex_shift_operand), 256'(12'h2FF));
    check("load_rm", 256'(ex_val_rm), 256'(32'h1234_5678));
    check("load_memcmd", 256'(ex_mem_cmd), 256'(1));
    check("load_valid", 256'(ex_valid), 256'(1));
    check("load_i", 256'(ex_i), 256'(1));
    check_model("load_imm");

    // Freeze for three cycles with changing inputs.
    snap_ctrl = obs_ctrl;
    snap_data = obs_data;
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      tick();
      check("freeze_hold", 256'({obs_ctrl, obs_data}), 256'({snap_ctrl, snap_data}));
    end
    freeze = 1'b0;
    tick();
    check_model("freeze_release");
    check("release_pc", 256'(ex_pc), 256'(id_pc));

    // Flush squashes a valid instruction.
    rand_inputs();
    id_wb_en = 1'b1; id_exe_cmd = 4'b0010; flush = 1'b1;
    tick();
    check("flush_wb", 256'(ex_wb_en), 256'(0));
    check("flush_cmd", 256'(ex_exe_cmd), 256'(0));
    check("flush_valid", 256'(ex_valid), 256'(0));
    check("flush_all", 256'({obs_ctrl, obs_data}), 256'(0));
    flush = 1'b0;

    // Flush and freeze together: bubble, not hold.
    rand_inputs();
    tick();
    check("pre_ff_valid", 256'(ex_valid), 256'(1));
    rand_inputs();
    flush = 1'b1; freeze = 1'b1;
    tick();
    check("flush_freeze_valid", 256'(ex_valid), 256'(0));
    check_model("flush_freeze");
    flush = 1'b0; freeze = 1'b0;

    // Invalid slot: controls forced to zero, data still loads.
    rand_inputs();
    id_valid = 1'b0; id_wb_en = 1'b1; id_mem_w_en = 1'b1; id_b = 1'b1; id_exe_cmd = 4'h7;
    tick();
    check("invalid_ctrl", 256'(obs_ctrl), 256'(0));
    check("invalid_pc", 256'(ex_pc), 256'(id_pc));
    check_model("invalid_load");

`ifdef FWD_SRC_EN
    rand_inputs();
    id_src1 = 4'd3; id_src2 = 4'd7;
    tick();
    check("fwd_src1", 256'(ex_src1), 256'(3));
    check("fwd_src2", 256'(ex_src2), 256'(7));
    flush = 1'b1;
    tick();
    check("fwd_flush", 256'({ex_src1, ex_src2}), 256'(0));
    flush = 1'b0;
`endif

    // Reset during a stall empties the register; next edge loads normally.
    rand_inputs();
    tick();
    freeze = 1'b1; rst = 1'b1;
    rand_inputs();
    tick();
    check("rst_in_freeze", 256'({obs_ctrl, obs_data}), 256'(0));
    freeze = 1'b0; rst = 1'b0;
    rand_inputs();
    tick();
    check_model("post_reset_load");

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      id_valid = ($urandom_range(0, 9) < 8);
      rst      = ($urandom_range(0, 49) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      freeze   = ($urandom_range(0, 4) == 0);
      tick();
      check_model("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
